// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues word-aligned data-cache requests over a
// req/ack handshake, formats load data and hands results to write-back as a one-cycle pulse.
module mem_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      VALID_IN,
    output logic                      READY_OUT,
    input  logic [DATA_WIDTH-1:0]     ALU_OUT_IN,
    input  logic [DATA_WIDTH-1:0]     STORE_DATA_IN,
    input  logic                      LOAD_IN,
    input  logic                      STORE_IN,
    input  logic [2:0]                FUNCT3_IN,
    input  logic [REG_ADDR_WIDTH-1:0] RD_ADDR_IN,
    input  logic                      RD_WRITE_IN,
    output logic                      DC_REQ,
    output logic                      DC_WE,
    output logic [ADDR_WIDTH-1:0]     DC_ADDR,
    output logic [3:0]                DC_WSTRB,
    output logic [DATA_WIDTH-1:0]     DC_WDATA,
    input  logic                      DC_ACK,
    input  logic [DATA_WIDTH-1:0]     DC_RDATA,
    output logic                      VALID_OUT,
    output logic [DATA_WIDTH-1:0]     ALU_OUT_OUT,
    output logic [DATA_WIDTH-1:0]     DATA_CACHE_OUT_DATA,
    output logic                      WRITE_BACK_MUX_SELECT_OUT,
    output logic [REG_ADDR_WIDTH-1:0] RD_ADDR_OUT,
    output logic                      RD_WRITE_OUT,
    output logic                      MEM_FAULT_OUT
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]                state;
    logic [1:0]                byte_off;
    logic [2:0]                funct3_q;
    logic                      is_load_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
    logic                      rd_write_q;
    logic [DATA_WIDTH-1:0]     alu_q;

    logic                  is_mem;
    logic                  illegal_f3;
    logic                  misaligned;
    logic                  fault;
    logic [3:0]            wstrb_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_fmt;

    assign READY_OUT = (state == IDLE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_mem     = LOAD_IN | STORE_IN;
        misaligned = ((FUNCT3_IN[1:0] == 2'b01) && ALU_OUT_IN[0]) ||
                     ((FUNCT3_IN[1:0] == 2'b10) && (ALU_OUT_IN[1:0] != 2'b00));
        if (LOAD_IN)
            illegal_f3 = !(FUNCT3_IN inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else
            illegal_f3 = !(FUNCT3_IN inside {3'b000, 3'b001, 3'b010});
        fault = (LOAD_IN && STORE_IN) || illegal_f3 || misaligned;

        wstrb_next = 4'b0000;
        wdata_next = STORE_DATA_IN;
        if (STORE_IN) begin
            case (FUNCT3_IN[1:0])
                2'b00: begin
                    wstrb_next = 4'b0001 << ALU_OUT_IN[1:0];
                    wdata_next = {4{STORE_DATA_IN[7:0]}};
                end
                2'b01: begin
                    wstrb_next = ALU_OUT_IN[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{STORE_DATA_IN[15:0]}};
                end
                default: wstrb_next = 4'b1111;
            endcase
        end
    end

    // Bring the addressed lane down to bit 0, then trim and extend by access size.
    always_comb begin
        shifted = DC_RDATA >> {byte_off, 3'b000};
        case (funct3_q)
            3'b000:  load_fmt = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_fmt = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_fmt = shifted;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state                     <= IDLE;
            byte_off                  <= '0;
            funct3_q                  <= '0;
            is_load_q                 <= 1'b0;
            rd_addr_q                 <= '0;
            rd_write_q                <= 1'b0;
            alu_q                     <= '0;
            DC_REQ                    <= 1'b0;
            DC_WE                     <= 1'b0;
            DC_ADDR                   <= '0;
            DC_WSTRB                  <= '0;
            DC_WDATA                  <= '0;
            VALID_OUT                 <= 1'b0;
            ALU_OUT_OUT               <= '0;
            DATA_CACHE_OUT_DATA       <= '0;
            WRITE_BACK_MUX_SELECT_OUT <= 1'b0;
            RD_ADDR_OUT               <= '0;
            RD_WRITE_OUT              <= 1'b0;
            MEM_FAULT_OUT             <= 1'b0;
        end else begin
            VALID_OUT     <= 1'b0;
            RD_WRITE_OUT  <= 1'b0;
            MEM_FAULT_OUT <= 1'b0;
            case (state)
                IDLE: begin
                    if (VALID_IN) begin
                        if (!is_mem || fault) begin
                            VALID_OUT                 <= 1'b1;
                            ALU_OUT_OUT               <= ALU_OUT_IN;
                            RD_ADDR_OUT               <= RD_ADDR_IN;
                            WRITE_BACK_MUX_SELECT_OUT <= 1'b0;
                            RD_WRITE_OUT              <= !is_mem && RD_WRITE_IN;
                            MEM_FAULT_OUT             <= is_mem;
                        end else begin
                            state      <= ACCESS;
                            DC_REQ     <= 1'b1;
                            DC_WE      <= STORE_IN;
                            DC_ADDR    <= {ALU_OUT_IN[ADDR_WIDTH-1:2], 2'b00};
                            DC_WSTRB   <= wstrb_next;
                            DC_WDATA   <= wdata_next;
                            byte_off   <= ALU_OUT_IN[1:0];
                            funct3_q   <= FUNCT3_IN;
                            is_load_q  <= LOAD_IN;
                            rd_addr_q  <= RD_ADDR_IN;
                            rd_write_q <= RD_WRITE_IN;
                            alu_q      <= ALU_OUT_IN;
                        end
                    end
                end
                default: begin
                    if (DC_ACK) begin
                        state                     <= IDLE;
                        DC_REQ                    <= 1'b0;
                        VALID_OUT                 <= 1'b1;
                        ALU_OUT_OUT               <= alu_q;
                        RD_ADDR_OUT               <= rd_addr_q;
                        WRITE_BACK_MUX_SELECT_OUT <= is_load_q;
                        RD_WRITE_OUT              <= is_load_q && rd_write_q;
                        if (is_load_q)
                            DATA_CACHE_OUT_DATA <= load_fmt;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of single-instruction vectors
// plus hand-written sequences for pulse width, spurious ack, busy stall and reset abort.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        VALID_IN;
    logic        READY_OUT;
    logic [31:0] ALU_OUT_IN;
    logic [31:0] STORE_DATA_IN;
    logic        LOAD_IN;
    logic        STORE_IN;
    logic [2:0]  FUNCT3_IN;
    logic [4:0]  RD_ADDR_IN;
    logic        RD_WRITE_IN;
    logic        DC_REQ;
    logic        DC_WE;
    logic [31:0] DC_ADDR;
    logic [3:0]  DC_WSTRB;
    logic [31:0] DC_WDATA;
    logic        DC_ACK;
    logic [31:0] DC_RDATA;
    logic        VALID_OUT;
    logic [31:0] ALU_OUT_OUT;
    logic [31:0] DATA_CACHE_OUT_DATA;
    logic        WRITE_BACK_MUX_SELECT_OUT;
    logic [4:0]  RD_ADDR_OUT;
    logic        RD_WRITE_OUT;
    logic        MEM_FAULT_OUT;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    mem_access_unit dut (
        .CLK                       (CLK),
        .RST_N                     (RST_N),
        .VALID_IN                  (VALID_IN),
        .READY_OUT                 (READY_OUT),
        .ALU_OUT_IN                (ALU_OUT_IN),
        .STORE_DATA_IN             (STORE_DATA_IN),
        .LOAD_IN                   (LOAD_IN),
        .STORE_IN                  (STORE_IN),
        .FUNCT3_IN                 (FUNCT3_IN),
        .RD_ADDR_IN                (RD_ADDR_IN),
        .RD_WRITE_IN               (RD_WRITE_IN),
        .DC_REQ                    (DC_REQ),
        .DC_WE                     (DC_WE),
        .DC_ADDR                   (DC_ADDR),
        .DC_WSTRB                  (DC_WSTRB),
        .DC_WDATA                  (DC_WDATA),
        .DC_ACK                    (DC_ACK),
        .DC_RDATA                  (DC_RDATA),
        .VALID_OUT                 (VALID_OUT),
        .ALU_OUT_OUT               (ALU_OUT_OUT),
        .DATA_CACHE_OUT_DATA       (DATA_CACHE_OUT_DATA),
        .WRITE_BACK_MUX_SELECT_OUT (WRITE_BACK_MUX_SELECT_OUT),
        .RD_ADDR_OUT               (RD_ADDR_OUT),
        .RD_WRITE_OUT              (RD_WRITE_OUT),
        .MEM_FAULT_OUT             (MEM_FAULT_OUT)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] rdata;
        int          waits;
        logic        acc;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        rwo;
        logic        mux;
        logic        fault;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] alu, input logic [31:0] sdata, input logic ld, input logic st,
        input logic [2:0] f3, input logic [4:0] rd, input logic rw, input logic [31:0] rdata,
        input int waits, input logic acc, input logic we, input logic [31:0] addr,
        input logic [3:0] strb, input logic [31:0] wdata, input logic [31:0] data,
        input logic rwo, input logic mux, input logic fault);
        vec_t v;
        v.alu = alu;   v.sdata = sdata; v.ld = ld;     v.st = st;
        v.f3 = f3;     v.rd = rd;       v.rw = rw;     v.rdata = rdata;
        v.waits = waits; v.acc = acc;   v.we = we;     v.addr = addr;
        v.strb = strb; v.wdata = wdata; v.data = data;
        v.rwo = rwo;   v.mux = mux;     v.fault = fault;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        VALID_IN = 1'b0; LOAD_IN = 1'b0; STORE_IN = 1'b0;
        FUNCT3_IN = 3'b000; ALU_OUT_IN = '0; STORE_DATA_IN = '0;
        RD_ADDR_IN = '0; RD_WRITE_IN = 1'b0;
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        VALID_IN = 1'b1; ALU_OUT_IN = t.alu; STORE_DATA_IN = t.sdata;
        LOAD_IN = t.ld; STORE_IN = t.st; FUNCT3_IN = t.f3;
        RD_ADDR_IN = t.rd; RD_WRITE_IN = t.rw;
        check($sformatf("v%0d ready_at_accept", idx), READY_OUT, 1);
        step();
        drive_idle();
        if (t.acc) begin
            check($sformatf("v%0d dc_req", idx), DC_REQ, 1);
            check($sformatf("v%0d dc_we", idx), DC_WE, t.we);
            check($sformatf("v%0d dc_addr", idx), DC_ADDR, t.addr);
            check($sformatf("v%0d dc_wstrb", idx), DC_WSTRB, t.strb);
            if (t.we)
                check($sformatf("v%0d dc_wdata", idx), DC_WDATA, t.wdata);
            check($sformatf("v%0d early_valid", idx), VALID_OUT, 0);
            for (int w = 0; w < t.waits; w++) begin
                step();
                check($sformatf("v%0d ready_busy", idx), READY_OUT, 0);
                check($sformatf("v%0d req_held", idx), DC_REQ, 1);
                check($sformatf("v%0d addr_held", idx), DC_ADDR, t.addr);
            end
            DC_ACK = 1'b1;
            DC_RDATA = t.rdata;
            step();
            DC_ACK = 1'b0;
            DC_RDATA = 32'hDEAD_0000;
        end
        check($sformatf("v%0d dc_req_after", idx), DC_REQ, 0);
        check($sformatf("v%0d valid", idx), VALID_OUT, 1);
        check($sformatf("v%0d fault", idx), MEM_FAULT_OUT, t.fault);
        check($sformatf("v%0d rd_write", idx), RD_WRITE_OUT, t.rwo);
        check($sformatf("v%0d mux", idx), WRITE_BACK_MUX_SELECT_OUT, t.mux);
        check($sformatf("v%0d rd_addr", idx), RD_ADDR_OUT, t.rd);
        check($sformatf("v%0d alu_out", idx), ALU_OUT_OUT, t.alu);
        if (t.acc && t.ld)
            check($sformatf("v%0d load_data", idx), DATA_CACHE_OUT_DATA, t.data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[17];
        //            alu           sdata         ld st f3      rd rw rdata         w  acc we addr          strb     wdata         data          rwo mux flt
        vecs[0]  = mk(32'h0000_1234, 32'h0,        0, 0, 3'b000, 5, 1, 32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0, 0);
        vecs[1]  = mk(32'h0000_0103, 32'h0,        1, 0, 3'b000, 7, 1, 32'h80AA_BBCC, 3, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80, 1, 1, 0);
        vecs[2]  = mk(32'h0000_0103, 32'h0,        1, 0, 3'b100, 7, 1, 32'h80AA_BBCC, 3, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080, 1, 1, 0);
        vecs[3]  = mk(32'h0000_0202, 32'hDEAD_BEEF, 0, 1, 3'b001, 4, 1, 32'h0,        1, 1, 1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 0, 0);
        vecs[4]  = mk(32'h0000_0301, 32'h0,        1, 0, 3'b010, 6, 1, 32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0, 1);
        vecs[5]  = mk(32'h0000_0100, 32'h0,        1, 0, 3'b011, 6, 1, 32'h0,        0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0, 1);
        vecs[6]  = mk(32'h0000_0040, 32'h0,        1, 0, 3'b010, 8, 1, 32'h1234_5678, 0, 1, 0, 32'h0000_0040, 4'b0000, 32'h0,        32'h1234_5678, 1, 1, 0);
        vecs[7]  = mk(32'h0000_0105, 32'h1122_3344, 0, 1, 3'b000, 0, 0, 32'h0,        0, 1, 1, 32'h0000_0104, 4'b0010, 32'h4444_4444, 32'h0,        0, 0, 0);
        vecs[8]  = mk(32'h0000_0102, 32'h0,        1, 0, 3'b001, 9, 1, 32'h8001_7FFF, 2, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_8001, 1, 1, 0);
        vecs[9]  = mk(32'h0000_0100, 32'h0,        1, 0, 3'b101, 10, 1, 32'h1234_F00D, 1, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,       32'h0000_F00D, 1, 1, 0);
        vecs[10] = mk(32'h0000_0010, 32'hCAFE_F00D, 0, 1, 3'b010, 0, 0, 32'h0,        0, 1, 1, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 32'h0,        0, 0, 0);
        vecs[11] = mk(32'h0000_0020, 32'h0,        1, 1, 3'b010, 11, 1, 32'h0,       0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0, 1);
        vecs[12] = mk(32'h0000_0201, 32'h0,        0, 1, 3'b001, 12, 1, 32'h0,       0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0, 1);
        vecs[13] = mk(32'h0000_0000, 32'h0,        0, 1, 3'b100, 13, 0, 32'h0,       0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0, 1);
        vecs[14] = mk(32'h0000_0101, 32'h0,        1, 0, 3'b000, 14, 1, 32'h80AA_BBCC, 0, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,       32'hFFFF_FFBB, 1, 1, 0);
        vecs[15] = mk(32'h0000_0101, 32'h0,        1, 0, 3'b001, 15, 1, 32'h0,       0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0, 1);
        vecs[16] = mk(32'h0000_0104, 32'h0,        1, 0, 3'b110, 16, 1, 32'h0,       0, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        0, 0, 1);

        RST_N = 1'b0;
        DC_ACK = 1'b0;
        DC_RDATA = '0;
        drive_idle();
        #12;
        check("reset ready", READY_OUT, 1);
        check("reset dc_req", DC_REQ, 0);
        check("reset valid", VALID_OUT, 0);
        check("reset alu_out", ALU_OUT_OUT, 0);
        check("reset dc_addr", DC_ADDR, 0);
        check("reset rd_write", RD_WRITE_OUT, 0);
        step();
        RST_N = 1'b1;
        step();

        // Vectors run back to back: each accept lands in the previous VALID_OUT cycle.
        for (int i = 0; i < 17; i++)
            run_vec(vecs[i], i);

        // Write-back outputs pulse for one cycle and then hold their data.
        run_vec(mk(32'h0000_ABCD, 32'h0, 0, 0, 3'b000, 17, 1, 32'h0, 0, 0, 0, 32'h0, 4'b0000,
                   32'h0, 32'h0, 1, 0, 0), 17);
        step();
        check("pulse valid_low", VALID_OUT, 0);
        check("pulse rd_write_low", RD_WRITE_OUT, 0);
        check("pulse alu_hold", ALU_OUT_OUT, 32'h0000_ABCD);

        // Spurious ack while idle.
        DC_ACK = 1'b1;
        DC_RDATA = 32'h5555_5555;
        step();
        DC_ACK = 1'b0;
        check("idle_ack valid", VALID_OUT, 0);
        check("idle_ack ready", READY_OUT, 1);
        check("idle_ack dc_req", DC_REQ, 0);

        // New instruction presented while busy must be ignored.
        VALID_IN = 1'b1; LOAD_IN = 1'b1; FUNCT3_IN = 3'b010;
        ALU_OUT_IN = 32'h0000_0040; RD_ADDR_IN = 5'd3; RD_WRITE_IN = 1'b1;
        step();
        LOAD_IN = 1'b0; ALU_OUT_IN = 32'h0000_0999; RD_ADDR_IN = 5'd9;
        step();
        check("busy ready", READY_OUT, 0);
        check("busy valid", VALID_OUT, 0);
        check("busy addr_stable", DC_ADDR, 32'h0000_0040);
        DC_ACK = 1'b1;
        DC_RDATA = 32'h0000_0055;
        step();
        drive_idle();
        DC_ACK = 1'b0;
        check("busy ack valid", VALID_OUT, 1);
        check("busy ack alu_out", ALU_OUT_OUT, 32'h0000_0040);
        check("busy ack rd_addr", RD_ADDR_OUT, 3);
        check("busy ack data", DATA_CACHE_OUT_DATA, 32'h0000_0055);
        step();
        check("busy ignored valid", VALID_OUT, 0);

        // Reset in the middle of an access aborts it.
        VALID_IN = 1'b1; LOAD_IN = 1'b1; FUNCT3_IN = 3'b010;
        ALU_OUT_IN = 32'h0000_0080; RD_ADDR_IN = 5'd2; RD_WRITE_IN = 1'b1;
        step();
        drive_idle();
        check("abort req_before", DC_REQ, 1);
        RST_N = 1'b0;
        #1;
        check("abort dc_req", DC_REQ, 0);
        check("abort ready", READY_OUT, 1);
        check("abort valid", VALID_OUT, 0);
        step();
        RST_N = 1'b1;
        DC_ACK = 1'b1;
        DC_RDATA = 32'hFFFF_FFFF;
        step();
        DC_ACK = 1'b0;
        check("stale_ack valid", VALID_OUT, 0);
        check("stale_ack dc_req", DC_REQ, 0);
        check("stale_ack ready", READY_OUT, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage load/store unit between execute and write-back. Takes the execute result, issues word-aligned read/write requests to the data cache with a req/ack handshake, and stalls upstream while an access is outstanding. Lane-aligns and sign/zero-extends load data. Delivers ALU result, formatted load data, write-back mux select and destination register to the write-back stage as a one-cycle valid pulse.

Parameters:
DATA_WIDTH, 32, datapath width; only 32 is supported (4 byte lanes)
ADDR_WIDTH, 32, byte address width
REG_ADDR_WIDTH, 5, destination register index width

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
VALID_IN  in  1  execute-stage instruction valid
READY_OUT  out  1  unit can accept an instruction this cycle
ALU_OUT_IN  in  DATA_WIDTH  ALU result; byte address for load/store
STORE_DATA_IN  in  DATA_WIDTH  rs2 value for stores
LOAD_IN  in  1  instruction is a load
STORE_IN  in  1  instruction is a store
FUNCT3_IN  in  3  access size/sign (RV32I encoding)
RD_ADDR_IN  in  REG_ADDR_WIDTH  destination register
RD_WRITE_IN  in  1  instruction writes rd
DC_REQ  out  1  data cache request
DC_WE  out  1  1 = write, 0 = read
DC_ADDR  out  ADDR_WIDTH  word address, bits[1:0] = 0
DC_WSTRB  out  4  byte write enables
DC_WDATA  out  DATA_WIDTH  lane-replicated store data
DC_ACK  in  1  cache completes request this cycle
DC_RDATA  in  DATA_WIDTH  read word, valid with DC_ACK on reads
VALID_OUT  out  1  one-cycle pulse, write-back outputs valid
ALU_OUT_OUT  out  DATA_WIDTH  registered ALU result
DATA_CACHE_OUT_DATA  out  DATA_WIDTH  formatted load data
WRITE_BACK_MUX_SELECT_OUT  out  1  1 = select load data, 0 = ALU result
RD_ADDR_OUT  out  REG_ADDR_WIDTH  destination register
RD_WRITE_OUT  out  1  register write enable, 0 whenever VALID_OUT = 0
MEM_FAULT_OUT  out  1  fault flag, qualified by VALID_OUT

Behaviour:
- Reset (RST_N low, async): state IDLE; READY_OUT = 1; DC_REQ, DC_WE, VALID_OUT, RD_WRITE_OUT, MEM_FAULT_OUT, WRITE_BACK_MUX_SELECT_OUT = 0; DC_ADDR, DC_WSTRB, DC_WDATA, ALU_OUT_OUT, DATA_CACHE_OUT_DATA, RD_ADDR_OUT = 0.
- States: IDLE, ACCESS. READY_OUT = 1 only in IDLE (registered, 0 in ACCESS). VALID_IN is ignored when READY_OUT = 0.
- IDLE, VALID_IN = 1, no load/store: next edge registers ALU_OUT_OUT and RD_ADDR_OUT; VALID_OUT = 1, RD_WRITE_OUT = RD_WRITE_IN, mux select 0. Latency 1; back-to-back accepts allowed.
- Fault check at accept: misaligned (halfword with addr[0] = 1, word with addr[1:0] != 0), illegal funct3 (load not in {000,001,010,100,101}, store not in {000,001,010}), or LOAD_IN and STORE_IN both 1. On fault: no cache request; next edge VALID_OUT = 1, MEM_FAULT_OUT = 1, RD_WRITE_OUT = 0.
- Legal access: next edge enters ACCESS with DC_REQ = 1. DC_ADDR = {addr[ADDR_WIDTH-1:2], 2'b00}. DC_WE = STORE_IN.
- Store strobes: SB: DC_WSTRB = 1 << addr[1:0], DC_WDATA = byte replicated x4. SH: DC_WSTRB = 0011 or 1100 by addr[1], DC_WDATA = half replicated x2. SW: DC_WSTRB = 1111, full word. Reads: DC_WSTRB = 0000.
- ACCESS: DC_REQ and all DC_* outputs held stable until DC_ACK is sampled 1. The cache may ack in the first ACCESS cycle (minimum) or after any wait.
- On the DC_ACK edge: DC_REQ = 0, state IDLE, VALID_OUT = 1 next cycle.
  - Load: DATA_CACHE_OUT_DATA = DC_RDATA >> (8*addr[1:0]), truncated to size and sign-extended (LB/LH) or zero-extended (LBU/LHU/LW); mux select 1; RD_WRITE_OUT = RD_WRITE_IN.
  - Store: RD_WRITE_OUT = 0, mux select 0.
  - A legal access therefore takes 2 + wait cycles from accept to VALID_OUT. The next instruction is accepted in the VALID_OUT cycle.
- VALID_OUT is a single-cycle pulse; write-back applies no backpressure. Data outputs hold their last values when VALID_OUT = 0.
- DC_ACK while in IDLE is ignored: no state change, no VALID_OUT.
- Reset during ACCESS drops DC_REQ immediately; no VALID_OUT for the aborted instruction. A stale DC_ACK after reset is ignored.

Test Plan:
- ALU op: VALID_IN=1, ALU_OUT_IN=0x0000_1234, RD_ADDR_IN=5, RD_WRITE_IN=1 -> next cycle VALID_OUT=1, ALU_OUT_OUT=0x1234, RD_ADDR_OUT=5, mux select 0, no DC_REQ.
- LB at 0x103, cache acks after 3 wait cycles with DC_RDATA=0x80AA_BBCC -> DC_ADDR=0x100; READY_OUT=0 throughout; DATA_CACHE_OUT_DATA=0xFFFF_FF80, mux select 1. Same access as LBU -> 0x0000_0080.
- SH at 0x202, STORE_DATA_IN=0xDEAD_BEEF -> DC_WE=1, DC_ADDR=0x200, DC_WSTRB=1100, DC_WDATA=0xBEEF_BEEF; after ack VALID_OUT=1, RD_WRITE_OUT=0.
- LW at 0x301 -> no DC_REQ; next cycle VALID_OUT=1, MEM_FAULT_OUT=1, RD_WRITE_OUT=0. Load with FUNCT3_IN=011 -> same fault response.
- Zero-wait ack: LW at 0x40, DC_ACK=1 in first ACCESS cycle, DC_RDATA=0x1234_5678 -> VALID_OUT two cycles after accept, data=0x1234_5678; a spurious DC_ACK in IDLE produces no VALID_OUT.
- RST_N low while in ACCESS -> DC_REQ=0 immediately, READY_OUT=1, no VALID_OUT; DC_ACK after reset release is ignored.
